// File: rtl/rom_pkg.sv
// Shared definitions for the ROM and its fetch unit: default ROM geometry,
// fetch FSM state encoding, the instruction presented when nothing is valid,
// and the PC increment.
// Build option: FETCH_MISALIGN_TRAP_EN adds the FAULT state to fetch_state_e.
package rom_pkg;

  localparam int ROM_ADDR_WIDTH = 8;
  localparam int ROM_DATA_WIDTH = 32;

  // Byte distance between consecutive instruction words.
  localparam int PC_STEP = 4;

  // Value held in the instruction register out of reset.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Fetch FSM states. FAULT only exists when misaligned redirects trap.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    FAULT = 2'd2
`endif
  } fetch_state_e;

  // A byte PC is word-aligned when its two low bits are zero.
  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register and next-PC selection for rom_fetch_unit.
// Priority: redirect target, then sequential increment, otherwise hold.
// The PC wraps modulo 2^PC_WIDTH with no indication.
// Build option: FETCH_MISALIGN_TRAP_EN exposes the redirect alignment check
// so the parent can trap instead of loading a misaligned target.
module fetch_pc_gen
  import rom_pkg::*;
#(
  parameter int                  PC_WIDTH = ROM_ADDR_WIDTH + 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                redirect_en_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  input  logic                advance_i,
  output logic [PC_WIDTH-1:0] fetch_pc_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                misaligned_o
`endif
);

  logic [PC_WIDTH-1:0] fetch_pc_d;
  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic [PC_WIDTH-1:0] target_aligned;

  // Targets are always word-aligned before loading; when trapping is enabled
  // the parent never asserts redirect_en_i for a misaligned target anyway.
  assign target_aligned = redirect_pc_i & ~PC_WIDTH'(PC_STEP - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned_o = is_misaligned(redirect_pc_i[1:0]);
`endif

  // Next-PC mux: redirect wins over sequential advance; otherwise hold.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_en_i) begin
      fetch_pc_d = target_aligned;
    end else if (advance_i) begin
      fetch_pc_d = fetch_pc_q + PC_WIDTH'(PC_STEP);
    end
  end

  // PC register with synchronous reset to RESET_PC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign fetch_pc_o = fetch_pc_q;

endmodule

// File: rtl/rom_fetch_unit.sv
// Instruction fetch unit between a combinational ROM and the decode stage.
// Drives the ROM word address from the fetch PC, registers the returned word
// with its byte PC, and offers it to decode with a valid/ready handshake.
// Supports stall, redirect and halt, sustaining one instruction per cycle.
// Build option: FETCH_MISALIGN_TRAP_EN makes a misaligned redirect enter a
// sticky FAULT state (fault_o=1, no further fetches until reset); without it
// the redirect target's low two bits are cleared and fault_o is tied low.
module rom_fetch_unit
  import rom_pkg::*;
#(
  parameter int                  ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int                  DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int                  PC_WIDTH   = ADDR_WIDTH + 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  input  logic                  halt_i,
  output logic                  fault_o,
  output fetch_state_e          state_o
);

  // Handshake toward decode: instr_o/pc_o are offered while valid_o is high
  // and stay stable until the cycle where valid_o && ready_i, which is the
  // transfer. valid_o never depends combinationally on ready_i, and a
  // transfer coinciding with a redirect still counts as accepted.

  logic [DATA_WIDTH-1:0] instr_d, instr_q;
  logic [PC_WIDTH-1:0]   pc_d, pc_q;
  logic                  valid_d, valid_q;
  fetch_state_e          state_d, state_q;

  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  load;
  logic                  redirect_take;
  logic                  advance;
  logic                  frozen;
  logic                  trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                  misaligned;
  logic                  fault_d, fault_q;
`endif

  fetch_pc_gen #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc_gen (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_en_i (redirect_take),
    .redirect_pc_i (redirect_pc_i),
    .advance_i     (advance),
    .fetch_pc_o    (fetch_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misaligned_o  (misaligned)
`endif
  );

  // The ROM answers in the same cycle, so the word address is the fetch PC.
  assign rom_addr_o = fetch_pc[PC_WIDTH-1:2];

`ifdef FETCH_MISALIGN_TRAP_EN
  assign frozen = (state_q == FAULT);
  assign trap   = redirect_i && misaligned;
`else
  assign frozen = 1'b0;
  assign trap   = 1'b0;
`endif

  // Next-state and output-register selection. Priority: fault freeze,
  // redirect (flushes the held instruction), halt (drain only), load.
  always_comb begin
    instr_d       = instr_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    redirect_take = 1'b0;
    advance       = 1'b0;
    load          = !valid_q || ready_i;

    if (frozen) begin
      valid_d = 1'b0;
    end else if (redirect_i) begin
      valid_d       = 1'b0;
      redirect_take = !trap;
    end else if (halt_i) begin
      if (valid_q && ready_i) begin
        valid_d = 1'b0;
      end
    end else if (load) begin
      instr_d = rom_data_i;
      pc_d    = fetch_pc;
      valid_d = 1'b1;
      advance = 1'b1;
    end

    // HALT means halt requested and nothing left to hand to decode.
    state_d = (halt_i && !valid_d) ? HALT : RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (frozen || trap) begin
      state_d = FAULT;
    end
    fault_d = fault_q || trap;
`endif
  end

  // FSM state and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= DATA_WIDTH'(INSTR_NOP);
      pc_q    <= '0;
      valid_q <= 1'b0;
      state_q <= RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      state_q <= state_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
  assign state_o = state_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

endmodule
